// File: rtl/speck_ks_round_decrypt.sv
// Single-step SPECK128/128 engine: one key-schedule step and one inverse round, each with its own FSM.
// Optional macro SPECK_DEBUG_STATE_EN exposes live FSM encodings on ks_state/rd_state.
module speck_ks_round_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         ks_start,
    input  logic [127:0] key,
    input  logic [63:0]  round_ctr,
    output logic [127:0] out_key,
    output logic         ks_finished,
    output logic [3:0]   ks_state,
    input  logic         rd_start,
    input  logic [63:0]  subkey,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         rd_finished,
    output logic [3:0]   rd_state
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] LOAD    = 4'd1;
    localparam logic [3:0] COMPUTE = 4'd2;
    localparam logic [3:0] DONE    = 4'd3;

    logic [3:0]  ks_st;
    logic [63:0] ks_k_r, ks_l_r, ks_ctr_r;
    logic [63:0] ks_l_next, ks_k_next;

    logic [3:0]  rd_st;
    logic [63:0] rd_x_r, rd_y_r, rd_sk_r;
    logic [63:0] rd_xy, rd_y_next, rd_diff, rd_x_next;

    // Key schedule: l' = (k + ROR(l,8)) ^ i ; k' = ROL(k,3) ^ l'
    always_comb begin
        ks_l_next = (ks_k_r + {ks_l_r[7:0], ks_l_r[63:8]}) ^ ks_ctr_r;
        ks_k_next = {ks_k_r[60:0], ks_k_r[63:61]} ^ ks_l_next;
    end

    // Inverse round: y' = ROR(x^y,3) ; x' = ROL((x^k) - y', 8)
    always_comb begin
        rd_xy     = rd_x_r ^ rd_y_r;
        rd_y_next = {rd_xy[2:0], rd_xy[63:3]};
        rd_diff   = (rd_x_r ^ rd_sk_r) - rd_y_next;
        rd_x_next = {rd_diff[55:0], rd_diff[63:56]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks_st       <= IDLE;
            ks_k_r      <= '0;
            ks_l_r      <= '0;
            ks_ctr_r    <= '0;
            out_key     <= '0;
            ks_finished <= 1'b0;
        end else begin
            case (ks_st)
                IDLE: begin
                    if (ks_start) ks_st <= LOAD;
                end
                LOAD: begin
                    ks_k_r      <= key[127:64];
                    ks_l_r      <= key[63:0];
                    ks_ctr_r    <= round_ctr;
                    ks_finished <= 1'b0;
                    ks_st       <= COMPUTE;
                end
                COMPUTE: begin
                    out_key     <= {ks_k_next, ks_l_next};
                    ks_finished <= 1'b1;
                    ks_st       <= DONE;
                end
                DONE: begin
                    if (ks_start) begin
                        ks_finished <= 1'b0;
                        ks_st       <= LOAD;
                    end
                end
                default: ks_st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st       <= IDLE;
            rd_x_r      <= '0;
            rd_y_r      <= '0;
            rd_sk_r     <= '0;
            plaintext   <= '0;
            rd_finished <= 1'b0;
        end else begin
            case (rd_st)
                IDLE: begin
                    if (rd_start) rd_st <= LOAD;
                end
                LOAD: begin
                    rd_x_r      <= ciphertext[127:64];
                    rd_y_r      <= ciphertext[63:0];
                    rd_sk_r     <= subkey;
                    rd_finished <= 1'b0;
                    rd_st       <= COMPUTE;
                end
                COMPUTE: begin
                    plaintext   <= {rd_x_next, rd_y_next};
                    rd_finished <= 1'b1;
                    rd_st       <= DONE;
                end
                DONE: begin
                    if (rd_start) begin
                        rd_finished <= 1'b0;
                        rd_st       <= LOAD;
                    end
                end
                default: rd_st <= IDLE;
            endcase
        end
    end

`ifdef SPECK_DEBUG_STATE_EN
    assign ks_state = ks_st;
    assign rd_state = rd_st;
`else
    assign ks_state = 4'h0;
    assign rd_state = 4'h0;
`endif

endmodule

// File: tb/tb_speck_ks_round_decrypt.sv
// Directed bench for speck_ks_round_decrypt: hand-computed vectors, handshake timing and async reset.
module tb_speck_ks_round_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         ks_start;
    logic [127:0] key;
    logic [63:0]  round_ctr;
    logic [127:0] out_key;
    logic         ks_finished;
    logic [3:0]   ks_state;
    logic         rd_start;
    logic [63:0]  subkey;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         rd_finished;
    logic [3:0]   rd_state;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KS_KEY_A = 128'h0706050403020100_0f0e0d0c0b0a0908;
    localparam logic [127:0] KS_EXP_A = 128'h37253b31171d0309_0f1513110f0d0b09;
    localparam logic [127:0] KS_EXP_B = 128'h0000000000000005_0000000000000005;
    localparam logic [127:0] CT_A     = 128'h0000000000000001_0000000000000000;
    localparam logic [127:0] PT_EXP_A = 128'h00000000000001e0_2000000000000000;
    localparam logic [127:0] PT_EXP_B = 128'hffffffffffffffff_0000000000000000;

    speck_ks_round_decrypt dut (
        .clk         (clk),
        .rst         (rst),
        .ks_start    (ks_start),
        .key         (key),
        .round_ctr   (round_ctr),
        .out_key     (out_key),
        .ks_finished (ks_finished),
        .ks_state    (ks_state),
        .rd_start    (rd_start),
        .subkey      (subkey),
        .ciphertext  (ciphertext),
        .plaintext   (plaintext),
        .rd_finished (rd_finished),
        .rd_state    (rd_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        ks_start   = 1'b0;
        rd_start   = 1'b0;
        key        = '0;
        round_ctr  = '0;
        subkey     = '0;
        ciphertext = '0;
        #12;
        chk("reset_out_key", out_key, '0);
        chk("reset_plaintext", plaintext, '0);
        chk("reset_finished", {126'd0, ks_finished, rd_finished}, '0);
        chk("reset_states", {120'd0, ks_state, rd_state}, '0);
        rst = 1'b0;
        step();

        // Both halves launched on the same edge with the standard / carry vectors
        key        = KS_KEY_A;
        round_ctr  = 64'd0;
        ciphertext = CT_A;
        subkey     = 64'd0;
        ks_start   = 1'b1;
        rd_start   = 1'b1;
        step();                       // IDLE -> LOAD
        ks_start = 1'b0;
        rd_start = 1'b0;
        chk("load_finished_low", {126'd0, ks_finished, rd_finished}, '0);
        step();                       // LOAD -> COMPUTE
        chk("compute_finished_low", {126'd0, ks_finished, rd_finished}, '0);
        chk("compute_out_key_hold", out_key, '0);
        // Inputs changed while in COMPUTE must not disturb the result
        key        = '0;
        round_ctr  = 64'd5;
        ciphertext = '0;
        subkey     = 64'hffffffffffffffff;
        step();                       // COMPUTE -> DONE
        chk("ks_vec_std", out_key, KS_EXP_A);
        chk("rd_vec_carry", plaintext, PT_EXP_A);
        chk("done_finished_high", {126'd0, ks_finished, rd_finished}, 128'd3);
        step();
        step();
        chk("done_hold_key", out_key, KS_EXP_A);
        chk("done_hold_pt", plaintext, PT_EXP_A);
        chk("done_hold_finished", {126'd0, ks_finished, rd_finished}, 128'd3);

        // Re-start from DONE with the counter-injection / key-only vectors
        ks_start = 1'b1;
        rd_start = 1'b1;
        step();                       // DONE -> LOAD
        ks_start = 1'b0;
        rd_start = 1'b0;
        chk("restart_finished_drop", {126'd0, ks_finished, rd_finished}, '0);
        chk("restart_key_hold", out_key, KS_EXP_A);
        step();
        chk("restart_compute_low", {126'd0, ks_finished, rd_finished}, '0);
        step();
        chk("ks_vec_ctr", out_key, KS_EXP_B);
        chk("rd_vec_keyonly", plaintext, PT_EXP_B);
        chk("restart_finished_high", {126'd0, ks_finished, rd_finished}, 128'd3);

        // Only KS relaunched; RD must stay in DONE untouched
        key       = KS_KEY_A;
        round_ctr = 64'd0;
        ks_start  = 1'b1;
        step();
        ks_start = 1'b0;
        chk("ks_only_flags", {126'd0, ks_finished, rd_finished}, 128'd1);
        step();
        step();
        chk("ks_only_key", out_key, KS_EXP_A);
        chk("ks_only_pt_hold", plaintext, PT_EXP_B);

        // Asynchronous reset in COMPUTE
        ks_start = 1'b1;
        rd_start = 1'b1;
        step();
        ks_start = 1'b0;
        rd_start = 1'b0;
        step();                       // now in COMPUTE
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_key", out_key, '0);
        chk("async_rst_plaintext", plaintext, '0);
        chk("async_rst_finished", {126'd0, ks_finished, rd_finished}, '0);
        chk("async_rst_states", {120'd0, ks_state, rd_state}, '0);
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("post_rst_idle", {126'd0, ks_finished, rd_finished}, '0);
        chk("post_rst_out_key", out_key, '0);

        // Held start re-launches every 3 cycles
        key       = '0;
        round_ctr = 64'd5;
        ks_start  = 1'b1;
        step();                       // LOAD
        step();                       // COMPUTE
        step();                       // DONE
        chk("held_done1", {127'd0, ks_finished}, 128'd1);
        chk("held_key1", out_key, KS_EXP_B);
        step();                       // LOAD again
        chk("held_relaunch_low", {127'd0, ks_finished}, '0);
        step();
        step();
        chk("held_done2", {127'd0, ks_finished}, 128'd1);
        ks_start = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
